// File: rtl/pool2d_stream.sv
// Streaming 2x2 / stride-2 max or average pooling over a row-major feature map.
// A half-row line buffer holds horizontal pair results of each even row until the odd row completes them.
module pool2d_stream #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_COLS = 64,
  parameter int unsigned MAX_ROWS = 64,
  parameter int unsigned SIGNED   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [$clog2(MAX_COLS):0]   cfg_cols,
  input  logic [$clog2(MAX_ROWS):0]   cfg_rows,
  input  logic                        cfg_mode,
  input  logic [WIDTH-1:0]            data_in,
  input  logic                        data_in_en,
  output logic [WIDTH-1:0]            data_out,
  output logic                        data_out_en,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned CW = $clog2(MAX_COLS) + 1;
  localparam int unsigned RW = $clog2(MAX_ROWS) + 1;
  localparam int unsigned BD = MAX_COLS / 2;
  localparam int unsigned BW = $clog2(BD);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cols_q, c;
  logic [RW-1:0]    rows_q, r;
  logic             mode_q;
  logic [WIDTH-1:0] pair;
  logic [WIDTH:0]   line_buf [BD];

  logic             accept, c_last, r_last, in_win, done_n, out_en_n;
  logic [WIDTH:0]   pe, xe, h, b;
  logic [WIDTH+1:0] sum4;
  logic [WIDTH-1:0] pooled;

  function automatic logic [WIDTH:0] ext1(input logic [WIDTH-1:0] x);
    return {(SIGNED != 0) && x[WIDTH-1], x};
  endfunction

  function automatic logic [WIDTH+1:0] ext2(input logic [WIDTH:0] x);
    return {(SIGNED != 0) && x[WIDTH], x};
  endfunction

  function automatic logic gt(input logic [WIDTH:0] a, input logic [WIDTH:0] y);
    return (SIGNED != 0) ? ($signed(a) > $signed(y)) : (a > y);
  endfunction

  // Datapath and next-state logic
  always_comb begin
    state_n  = state;
    done_n   = 1'b0;
    out_en_n = 1'b0;
    accept   = (state == RUN) && data_in_en;
    c_last   = (c == cols_q - CW'(1));
    r_last   = (r == rows_q - RW'(1));
    in_win   = (c < (cols_q & ~CW'(1))) && (r < (rows_q & ~RW'(1)));
    pe       = ext1(pair);
    xe       = ext1(data_in);
    h        = mode_q ? (pe + xe) : (gt(pe, xe) ? pe : xe);
    b        = line_buf[BW'(c >> 1)];
    sum4     = ext2(h) + ext2(b);
    // After truncation to WIDTH, arithmetic and logical >>2 yield the same bits
    pooled   = mode_q ? WIDTH'(sum4 >> 2) : (gt(h, b) ? h[WIDTH-1:0] : b[WIDTH-1:0]);
    case (state)
      IDLE: begin
        if (start) begin
          if ((cfg_cols < CW'(2)) || (cfg_rows < RW'(2))) done_n = 1'b1;
          else state_n = RUN;
        end
      end
      RUN: begin
        out_en_n = accept && in_win && c[0] && r[0];
        if (accept && c_last && r_last) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Config latch, counters, pair register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cols_q      <= '0;
      rows_q      <= '0;
      mode_q      <= 1'b0;
      c           <= '0;
      r           <= '0;
      pair        <= '0;
      data_out    <= '0;
      data_out_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done        <= done_n;
      data_out_en <= out_en_n;
      data_out    <= out_en_n ? pooled : '0;
      busy        <= (state_n == RUN);
      if (state == IDLE) begin
        c <= '0;
        r <= '0;
        if (start) begin
          cols_q <= cfg_cols;
          rows_q <= cfg_rows;
          mode_q <= cfg_mode;
        end
      end else if (accept) begin
        if (in_win && !c[0]) pair <= data_in;
        if (c_last) begin
          c <= '0;
          r <= r_last ? '0 : r + RW'(1);
        end else begin
          c <= c + CW'(1);
        end
      end
    end
  end

  // Even rows park horizontal results; contents need no reset
  always_ff @(posedge clk) begin
    if (accept && in_win && c[0] && !r[0]) line_buf[BW'(c >> 1)] <= h;
  end

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench for pool2d_stream: table of frames plus reset-abort sequence, checked every cycle.
module tb_pool2d_stream;

  logic        clk = 1'b0;
  logic        rst, start, cfg_mode, data_in_en;
  logic [6:0]  cfg_cols, cfg_rows;
  logic [15:0] data_in, data_out;
  logic        data_out_en, busy, done;

  pool2d_stream #(.WIDTH(16), .MAX_COLS(64), .MAX_ROWS(64), .SIGNED(1)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .cfg_mode(cfg_mode), .data_in(data_in), .data_in_en(data_in_en),
    .data_out(data_out), .data_out_en(data_out_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cols;
    int               rows;
    logic             mode;
    logic             gap;
    logic             ramp;
    logic [15:0]      first_v;
    logic [15:0]      cst;
    int               n_exp;
    logic [3:0][15:0] ev;
  } vec_t;

  vec_t        tv [9];
  int          n_checks, n_fail, n_seen;
  logic        e_en, e_done, e_busy;
  logic [15:0] e_val;

  function automatic vec_t mk(input int cols, input int rows, input logic mode, input logic gap,
                              input logic ramp, input logic [15:0] first_v, input logic [15:0] cst,
                              input int n_exp, input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3);
    vec_t v;
    v.cols = cols; v.rows = rows; v.mode = mode; v.gap = gap; v.ramp = ramp;
    v.first_v = first_v; v.cst = cst; v.n_exp = n_exp;
    v.ev[0] = e0; v.ev[1] = e1; v.ev[2] = e2; v.ev[3] = e3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_cycle(input string tag);
    if (data_out_en === 1'b1) n_seen++;
    chk({tag, " data_out_en"}, 32'(data_out_en), 32'(e_en));
    chk({tag, " data_out"}, 32'(data_out), e_en ? 32'(e_val) : 32'd0);
    chk({tag, " done"}, 32'(done), 32'(e_done));
    chk({tag, " busy"}, 32'(busy), 32'(e_busy));
  endtask

  // Assumes we sit on a negedge with the previous cycle already checked
  task automatic run_frame(input vec_t v, input string tag);
    int   k, rr, cc, cols_e, rows_e;
    logic degen, last;
    n_seen = 0;
    degen = (v.cols < 2) || (v.rows < 2);
    start = 1'b1; cfg_cols = 7'(v.cols); cfg_rows = 7'(v.rows); cfg_mode = v.mode;
    data_in_en = 1'b0; data_in = 16'($urandom);
    e_en = 1'b0; e_done = degen; e_busy = !degen;
    @(negedge clk); check_cycle({tag, " start"});
    start = 1'b0; cfg_cols = 7'd2; cfg_rows = 7'd2; cfg_mode = !v.mode;
    if (degen) begin
      e_done = 1'b0; e_busy = 1'b0;
      @(negedge clk); check_cycle({tag, " degen"});
    end else begin
      k = 0;
      cols_e = v.cols & ~1;
      rows_e = v.rows & ~1;
      for (int i = 0; i < v.cols * v.rows; i++) begin
        rr = i / v.cols;
        cc = i % v.cols;
        if (v.gap && i > 0) begin
          for (int g = 0; g < 2; g++) begin
            data_in_en = 1'b0; data_in = 16'($urandom);
            start = (i == 2 && g == 1);
            e_en = 1'b0; e_done = 1'b0; e_busy = 1'b1;
            @(negedge clk); check_cycle({tag, " gap"});
          end
        end
        start = 1'b0;
        data_in_en = 1'b1;
        data_in = v.ramp ? 16'(i) : ((i == 0) ? v.first_v : v.cst);
        e_en = (cc % 2 == 1) && (rr % 2 == 1) && (cc < cols_e) && (rr < rows_e);
        e_val = 16'h0;
        if (e_en) begin
          e_val = (k < 4) ? v.ev[k] : 16'h0;
          k++;
        end
        last = (i == v.cols * v.rows - 1);
        e_done = last; e_busy = !last;
        @(negedge clk); check_cycle($sformatf("%s px%0d", tag, i));
      end
    end
    chk({tag, " output count"}, 32'(n_seen), 32'(v.n_exp));
    data_in_en = 1'b0;
    e_en = 1'b0; e_done = 1'b0; e_busy = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_seen = 0;
    rst = 1'b1; start = 1'b0; cfg_cols = '0; cfg_rows = '0; cfg_mode = 1'b0;
    data_in_en = 1'b0; data_in = '0;
    e_en = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_val = '0;

    tv[0] = mk(4, 4, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 4, 16'd5, 16'd7, 16'd13, 16'd15);
    tv[1] = mk(4, 4, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0, 4, 16'd2, 16'd4, 16'd10, 16'd12);
    tv[2] = mk(2, 2, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFE, 1, 16'hFFFE, 16'h0, 16'h0, 16'h0);
    tv[3] = mk(2, 2, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFE, 1, 16'hFFFF, 16'h0, 16'h0, 16'h0);
    tv[4] = mk(5, 5, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 4, 16'd6, 16'd8, 16'd16, 16'd18);
    tv[5] = mk(4, 2, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0, 2, 16'd5, 16'd7, 16'h0, 16'h0);
    tv[6] = mk(1, 4, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
    tv[7] = mk(4, 1, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
    tv[8] = mk(4, 4, 1'b0, 1'b0, 1'b0, 16'h3, 16'h3, 4, 16'd3, 16'd3, 16'd3, 16'd3);

    repeat (3) @(negedge clk);
    check_cycle("reset");
    rst = 1'b0;
    @(negedge clk); check_cycle("idle");
    data_in_en = 1'b1; data_in = 16'h1234;
    @(negedge clk); check_cycle("idle data_in_en");

    for (int t = 0; t < 8; t++) run_frame(tv[t], $sformatf("vec%0d", t));
    @(negedge clk); check_cycle("between");

    // Abort a 4x4 frame: reset lands on the edge that would accept pixel 5 (r=1,c=1)
    start = 1'b1; cfg_cols = 7'd4; cfg_rows = 7'd4; cfg_mode = 1'b0;
    e_busy = 1'b1;
    @(negedge clk); check_cycle("abort start");
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_in_en = 1'b1; data_in = 16'(i + 100);
      @(negedge clk); check_cycle($sformatf("abort px%0d", i));
    end
    data_in = 16'd200; rst = 1'b1;
    e_busy = 1'b0;
    @(negedge clk); check_cycle("abort reset0");
    data_in = 16'd300;
    @(negedge clk); check_cycle("abort reset1");
    rst = 1'b0; data_in_en = 1'b0;
    @(negedge clk); check_cycle("abort idle");

    run_frame(tv[8], "after_reset");
    @(negedge clk); check_cycle("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
